// File: rtl/ln_iter_if.sv
// Operand/result handshake bundle for ln_iter: valid/ready on the operand side
// and on the result side. The slave modport is the unit, the master its driver.
interface ln_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  err;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/ln_iter.sv
// Iterative float32 natural log: log2 mantissa bits by repeated squaring, scaled by ln2.
// Optional LN_ITER_ROUND_EN switches the final mantissa from truncation to round-to-nearest.
module ln_iter #(
  parameter int ITER = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  ln_iter_if.slave   bus
);

  localparam int          LW  = ITER + 8;   // {e, frac} width
  localparam int          PW  = ITER + 39;  // |L| * ln2 product width
  localparam logic [31:0] LN2 = 32'hB172_17F8;

  typedef enum logic [2:0] {S_IDLE, S_ITER, S_SCALE, S_NORM, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_INVALID = 2'b01, ERR_ZERO = 2'b10} err_t;

  state_t          state;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [31:0]     result_q;
  logic [1:0]      err_q;
  logic [23:0]     m;
  logic [ITER-1:0] frac;
  logic [4:0]      k;
  logic [7:0]      e;
  logic            s;
  logic [PW-1:0]   p_reg;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

  // Operand fields
  logic        x_sign;
  logic [7:0]  x_exp;
  logic [22:0] x_mant;
  assign x_sign = bus.x[31];
  assign x_exp  = bus.x[30:23];
  assign x_mant = bus.x[22:0];

  // Squaring step: sq_hi holds bits [47:23] of m*m (Q2.46)
  logic [24:0] sq_hi;
  logic [23:0] m_next;
  assign sq_hi  = 25'(({24'd0, m} * {24'd0, m}) >> 23);
  assign m_next = sq_hi[24] ? sq_hi[24:1] : sq_hi[23:0];

  // Scale: L = {e, frac} is log2(x) in signed Q8.ITER
  logic [LW-1:0] l_val;
  logic [LW-1:0] l_abs;
  logic [PW-1:0] p_next;
  assign l_val  = {e, frac};
  assign l_abs  = l_val[LW-1] ? -l_val : l_val;
  assign p_next = PW'(l_abs) * PW'(LN2);

  // Leading-one position of P; the highest set bit wins
  logic [5:0] lead;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    lead = '0;
    for (int i = 0; i < PW; i++) begin
      if (p_reg[i]) lead = 6'(i);
    end
  end

  logic [5:0]  shamt;
  logic [7:0]  exp_n;
  logic [22:0] mant_n;
  logic [31:0] norm_word;
  assign shamt = 6'(PW - 1) - lead;

`ifdef LN_ITER_ROUND_EN
  logic [23:0] top;    // 23 mantissa bits followed by the first dropped bit
  logic [23:0] mant_r;
  assign top    = 24'((p_reg << shamt) >> (PW - 25));
  assign mant_r = {1'b0, top[23:1]} + {23'd0, top[0]};
  always_comb begin
    exp_n  = 8'(lead) + 8'(95 - ITER);
    mant_n = mant_r[22:0];
    if (mant_r[23]) begin
      mant_n = '0;
      exp_n  = exp_n + 8'd1;
    end
  end
`else
  assign exp_n  = 8'(lead) + 8'(95 - ITER);
  assign mant_n = 23'((p_reg << shamt) >> (PW - 24));
`endif

  assign norm_word = (p_reg == '0) ? 32'h0000_0000 : {s, exp_n, mant_n};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= ERR_OK;
      m           <= '0;
      frac        <= '0;
      k           <= '0;
      e           <= '0;
      s           <= 1'b0;
      p_reg       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (x_exp == 8'h00) begin
              // Zero and denormals of either sign are flushed to ln(0)
              result_q <= 32'hFF80_0000;
              err_q    <= ERR_ZERO;
              state    <= S_DONE;
            end else if ((x_exp == 8'hFF && x_mant != '0) || x_sign) begin
              result_q <= 32'h7FC0_0000;
              err_q    <= ERR_INVALID;
              state    <= S_DONE;
            end else if (x_exp == 8'hFF) begin
              result_q <= 32'h7F80_0000;
              err_q    <= ERR_OK;
              state    <= S_DONE;
            end else begin
              e     <= x_exp - 8'd127;
              m     <= {1'b1, x_mant};
              frac  <= '0;
              k     <= '0;
              state <= S_ITER;
            end
          end
        end

        S_ITER: begin
          m    <= m_next;
          frac <= {frac[ITER-2:0], sq_hi[24]};
          k    <= k + 5'd1;
          if (k == 5'(ITER - 1)) state <= S_SCALE;
        end

        S_SCALE: begin
          p_reg <= p_next;
          s     <= l_val[LW-1];
          state <= S_NORM;
        end

        S_NORM: begin
          result_q    <= norm_word;
          err_q       <= ERR_OK;
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end

        S_DONE: begin
          // Special cases arrive here with out_valid low and raise it one edge later
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
